// File: rtl/win_seq_ctrl.sv
// Frame sequencer for the 3x3 line-buffered window generator.
// Accepts pixels from a valid/ready source and drives the window's one-hot
// state and en_1. It also tracks row and column, inserts the pad column and
// the trailing flush line, and tags window advances that carry a valid
// centre pixel.
// Optional build macro: WIN_SYNC_CHK_EN adds a sticky check that not_ready
// from the window matches the sequencer's own pad-column position.
module win_seq_ctrl #(
  parameter int unsigned LINE_W = 1024,
  parameter int unsigned ROWS   = 1024,
  parameter int unsigned CW     = $clog2(LINE_W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  output logic [7:0]    pix_out,
  output logic          en_1,
  output logic [3:0]    state,
  input  logic          not_ready,
  output logic          out_valid,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy,
  output logic          frame_done,
  output logic          sync_err
);

  typedef enum logic [3:0] {
    ST_FILL  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_FLUSH = 4'b0100,
    ST_IDLE  = 4'b1000
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          frame_done_q, frame_done_d;

  logic          active;
  logic          adv;
  logic          col_wrap;
  logic          start_ok;
  logic [CW-1:0] c_prev;

  // Source handshake, window advance and column bookkeeping
  assign active   = (state_q == ST_FILL) || (state_q == ST_RUN);
  assign s_ready  = active && !not_ready;
  assign en_1     = s_valid && s_ready;
  assign pix_out  = en_1 ? s_data : 8'd0;
  assign adv      = en_1 || (active && not_ready) || (state_q == ST_FLUSH);
  assign col_wrap = (col_q == CW'(LINE_W));
  // The window's centre lags the input by one column (mod line period)
  assign c_prev   = (col_q == '0) ? CW'(LINE_W) : col_q - CW'(1);
  // A start coinciding with frame_done is dropped
  assign start_ok = (state_q == ST_IDLE) && start && !frame_done_q;

  assign state      = state_q;
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

  // Next-state, counter and centre-pixel tag logic
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    out_valid_d  = 1'b0;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    frame_done_d = 1'b0;

    if (adv) begin
      if (col_wrap) begin
        col_d = '0;
        row_d = row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (adv && ((state_q == ST_RUN) || (state_q == ST_FLUSH)) &&
        (c_prev < CW'(LINE_W))) begin
      out_valid_d = 1'b1;
      out_col_d   = c_prev;
      out_row_d   = (state_q == ST_RUN) ? row_q - CW'(1) : CW'(ROWS - 1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_FILL;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_FILL: begin
        if (adv && col_wrap && (row_q == '0)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (adv && col_wrap && (row_q == CW'(ROWS - 1))) begin
          state_d = ST_FLUSH;
          row_d   = '0;
        end
      end
      ST_FLUSH: begin
        if (adv && col_wrap) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef WIN_SYNC_CHK_EN
  logic sync_err_q, sync_err_d;

  // Sticky flag when the window's pad indicator disagrees with col_cnt
  always_comb begin
    sync_err_d = sync_err_q;
    if (start_ok) begin
      sync_err_d = 1'b0;
    end else if (active && (not_ready != col_wrap)) begin
      sync_err_d = 1'b1;
    end
  end

  // Sync error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_err_q <= 1'b0;
    else        sync_err_q <= sync_err_d;
  end

  assign sync_err = sync_err_q;
`else
  assign sync_err = 1'b0;
`endif

endmodule

// File: tb/tb_win_seq_ctrl.sv
// Self-checking bench for win_seq_ctrl (LINE_W=8, ROWS=4).
// A cycle model predicts every output; centre-pixel tags are queued when the
// modelled advance happens and popped when the DUT raises out_valid.
module tb_win_seq_ctrl;

  localparam int unsigned LW = 8;
  localparam int unsigned RW = 4;
  localparam int unsigned CW = $clog2(LW + 1);
  localparam int FRAME_ADV = (RW + 1) * (LW + 1);
  localparam logic [3:0] S_FILL  = 4'b0001;
  localparam logic [3:0] S_RUN   = 4'b0010;
  localparam logic [3:0] S_FLUSH = 4'b0100;
  localparam logic [3:0] S_IDLE  = 4'b1000;
  localparam int M_NORMAL = 0, M_STALL = 1, M_GLITCH = 2, M_START = 3,
                 M_RST = 4, M_RAND = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          s_ready;
  logic [7:0]    pix_out;
  logic          en_1;
  logic [3:0]    state;
  logic          not_ready = 1'b0;
  logic          out_valid;
  logic [CW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          busy;
  logic          frame_done;
  logic          sync_err;

  win_seq_ctrl #(.LINE_W(LW), .ROWS(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid),
    .s_data(s_data), .s_ready(s_ready), .pix_out(pix_out), .en_1(en_1),
    .state(state), .not_ready(not_ready), .out_valid(out_valid),
    .out_row(out_row), .out_col(out_col), .busy(busy),
    .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct { int row; int col; } tag_t;
  tag_t sb[$];

  int n_chk = 0;
  int n_fail = 0;

  // model state
  logic [3:0] m_st;
  int  m_col, m_row, m_orow, m_ocol;
  bit  m_ov, m_fd, m_se;
  int  c_adv, c_en, c_ov, c_fd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_col = 0; m_row = 0; m_orow = 0; m_ocol = 0;
    m_ov = 0; m_fd = 0; m_se = 0;
    sb.delete();
  endtask

  // One clock: check at negedge, advance model, return at posedge+1
  task automatic step();
    bit act, e_rdy, e_en, e_adv, fd_n, dut_adv;
    int c;
    tag_t t;
    @(negedge clk);
    act   = (m_st == S_FILL) || (m_st == S_RUN);
    e_rdy = act && !not_ready;
    e_en  = s_valid && e_rdy;
    e_adv = e_en || (act && not_ready) || (m_st == S_FLUSH);

    chk("state", 32'(state), 32'(m_st));
    chk("s_ready", 32'(s_ready), 32'(e_rdy));
    chk("en_1", 32'(en_1), 32'(e_en));
    chk("pix_out", 32'(pix_out), e_en ? 32'(s_data) : 32'd0);
    chk("busy", 32'(busy), 32'(m_st != S_IDLE));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_row", 32'(out_row), 32'(m_orow));
    chk("out_col", 32'(out_col), 32'(m_ocol));
    chk("sync_err", 32'(sync_err), 32'(m_se));
    if (sb.size() > 0) begin
      t = sb.pop_front();
      if (out_valid === 1'b1) begin
        chk("sb_row", 32'(out_row), 32'(t.row));
        chk("sb_col", 32'(out_col), 32'(t.col));
      end
    end else if (out_valid === 1'b1) begin
      chk("sb_unexpected", 32'd1, 32'd0);
    end

    dut_adv = en_1 || ((state[0] || state[1]) && not_ready) || state[2];
    if (dut_adv) c_adv++;
    if (en_1) c_en++;
    if (out_valid) c_ov++;
    if (frame_done) c_fd++;

    if (rst_n) begin
      m_ov = 0;
      fd_n = 0;
      if (e_adv && (m_st == S_RUN || m_st == S_FLUSH)) begin
        c = (m_col == 0) ? int'(LW) : m_col - 1;
        if (c < int'(LW)) begin
          m_ov = 1;
          m_ocol = c;
          m_orow = (m_st == S_RUN) ? m_row - 1 : int'(RW) - 1;
          sb.push_back('{m_orow, m_ocol});
        end
      end
`ifdef WIN_SYNC_CHK_EN
      if (act && (not_ready != (m_col == int'(LW)))) m_se = 1;
`endif
      if (m_st == S_IDLE) begin
        if (start && !m_fd) begin
          m_st = S_FILL; m_col = 0; m_row = 0; m_se = 0;
        end
      end else if (e_adv) begin
        if (m_col == int'(LW)) begin
          m_col = 0;
          if (m_st == S_FILL) begin
            m_row++; m_st = S_RUN;
          end else if (m_st == S_RUN) begin
            if (m_row == int'(RW) - 1) begin
              m_row = 0; m_st = S_FLUSH;
            end else begin
              m_row++;
            end
          end else begin
            m_st = S_IDLE; fd_n = 1;
          end
        end else begin
          m_col++;
        end
      end
      m_fd = fd_n;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; not_ready = 1'b0;
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input int mode, input int exp_en);
    int cyc = 0;
    int stall = 0;
    bit glitched = 0;
    c_adv = 0; c_en = 0; c_ov = 0; c_fd = 0;
    start = 1'b1; s_valid = 1'b1; s_data = 8'($urandom);
    not_ready = (m_col == int'(LW));
    step();
    while (cyc < 400 && m_st != S_IDLE) begin
      start = 1'b0;
      s_valid = 1'b1;
      s_data = 8'($urandom);
      not_ready = (m_col == int'(LW));
      if (mode == M_STALL && m_st == S_RUN && m_row == 2 && m_col == 5 && stall < 3) begin
        s_valid = 1'b0; stall++;
      end
      if (mode == M_GLITCH && !glitched && m_st == S_RUN && m_row == 1 && m_col == 3) begin
        not_ready = 1'b1; glitched = 1;
      end
      if (mode == M_START && m_st == S_RUN) start = 1'b1;
      if (mode == M_RAND) s_valid = ($urandom_range(0, 3) != 0);
      if (mode == M_RST && m_st == S_RUN && m_row == 2 && m_col == 0) begin
        apply_reset();
        return;
      end
      step();
      cyc++;
    end
    if (cyc >= 400) chk("frame_timeout", 32'd1, 32'd0);
    // start coinciding with frame_done must be dropped
    start = 1'b1; s_valid = 1'b0; not_ready = 1'b0;
    step();
    start = 1'b0;
    step();
    chk("adv_count", 32'(c_adv), 32'(FRAME_ADV));
    chk("en_count", 32'(c_en), 32'(exp_en));
    chk("ov_count", 32'(c_ov), 32'(LW * RW));
    chk("fd_count", 32'(c_fd), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    apply_reset();
    run_frame(M_NORMAL, int'(LW * RW));
    run_frame(M_STALL, int'(LW * RW));
    run_frame(M_GLITCH, int'(LW * RW) - 1);
`ifdef WIN_SYNC_CHK_EN
    chk("sync_sticky", 32'(sync_err), 32'd1);
`else
    chk("sync_sticky", 32'(sync_err), 32'd0);
`endif
    run_frame(M_START, int'(LW * RW));
    chk("sync_cleared", 32'(sync_err), 32'd0);
    run_frame(M_RST, 0);
    run_frame(M_NORMAL, int'(LW * RW));
    run_frame(M_RAND, int'(LW * RW));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/win_seq_ctrl.md
Name: win_seq_ctrl

Overview:
Frame sequencer for the 3x3 line-buffered window generator. Drives the window's one-hot `state` and `en_1`, and feeds it pixels from a valid/ready stream. It tracks row and column, inserts the pad column and the trailing flush line, and flags which window advances carry a valid centre pixel. Sits between the pixel source and the window block.

Parameters:
- LINE_W, 1024, active pixels per line; the window line period is LINE_W+1 (index LINE_W is the pad column).
- ROWS, 1024, active lines per frame.
- CW, $clog2(LINE_W+1), column/row counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  frame start pulse; honoured only in IDLE
- s_valid  in  1  source pixel valid
- s_data  in  8  source pixel
- s_ready  out  1  source pixel accepted when s_valid&&s_ready
- pix_out  out  8  pixel to window pix_in
- en_1  out  1  window input advance
- state  out  4  one-hot window state: 0001 FILL, 0010 RUN, 0100 FLUSH, 1000 IDLE
- not_ready  in  1  window pad-column indicator
- out_valid  out  1  window centre pixel valid (registered)
- out_row  out  CW  row of centre pixel
- out_col  out  CW  column of centre pixel
- busy  out  1  state!=IDLE
- frame_done  out  1  one-cycle pulse at end of FLUSH
- sync_err  out  1  see Optional Feature

Behaviour:
- Reset: state=1000; col_cnt=0, row_cnt=0; s_ready, en_1, out_valid, frame_done, sync_err all 0; out_row, out_col 0.
- s_ready = (FILL|RUN) && !not_ready, combinational.
- en_1 = s_valid && s_ready.
- pix_out = s_data when en_1, else 0.
- adv (window advance this cycle) = en_1 || ((FILL|RUN) && not_ready) || FLUSH. This mirrors the window's en_window.
- col_cnt increments on adv and wraps LINE_W -> 0. On wrap, row_cnt increments.
- An incomplete line never ends early; the pad column (col_cnt==LINE_W) advances without consuming source data.
- IDLE: start -> FILL; clear col_cnt, row_cnt and sync_err.
- FILL: on wrap with row_cnt==0 -> RUN.
- RUN: on wrap with row_cnt==ROWS-1 -> FLUSH; row_cnt wraps to 0 for the flush line.
- FLUSH: advance every cycle with pix_out=0. After exactly LINE_W+1 advances (col wrap) -> IDLE and frame_done=1 for one cycle.
- Each frame therefore consumes (ROWS+1)*(LINE_W+1) advances. This keeps the window's line-buffer address phase aligned at 0 between frames; an implementation must never cut FLUSH short.
- out_valid is registered. It is 1 the cycle after an adv in RUN or FLUSH where c=(col_cnt-1) mod (LINE_W+1) < LINE_W.
  - out_col = c at that adv.
  - out_row = row_cnt-1 in RUN, ROWS-1 in FLUSH.
  - Otherwise out_valid=0 and out_row/out_col hold.
- Stalls: s_valid=0 in FILL/RUN (not pad) -> no adv, counters hold, out_valid=0 next cycle.
- start while busy: ignored. Simultaneous frame_done and start: start ignored; a new start is accepted the cycle after IDLE is entered.
- rst_n mid-frame: immediate return to reset values. The window block shares rst_n, so its pointers realign.

Optional Feature:
- Macro WIN_SYNC_CHK_EN.
- Defined: each cycle in FILL/RUN, if not_ready != (col_cnt==LINE_W), set sync_err=1. It is sticky until start in IDLE or reset, and the state machine continues unaffected.
- Undefined: sync_err tied 0 and no compare logic is built.

Test Plan:
1. Reset, LINE_W=8, ROWS=4 -> state=1000, s_ready=0, en_1=0, busy=0, frame_done=0, out_valid=0.
2. start, s_valid held 1, window pad at col 8 -> FILL 9 advances, RUN 27, FLUSH 9; 32 pixels accepted; 32 out_valid pulses covering rows 0..3 × cols 0..7; frame_done one pulse after the 45th advance.
3. Mid-row s_valid=0 for 3 cycles at col 5 -> en_1=0, col_cnt holds 5, no out_valid for those cycles, then resume at col 5.
4. Pad column: col_cnt=8, s_valid=1 -> s_ready=0, en_1=0, pix_out=0, col_cnt wraps 0, row_cnt+1.
5. start pulsed during RUN -> ignored; rst_n low at row 2 -> state=1000, counters 0; new frame completes normally with 45 advances.
6. WIN_SYNC_CHK_EN defined: not_ready forced 1 at col 3 -> sync_err=1 from the next cycle, held through frame_done, cleared by next start.
